temperature_sampler: RTL and testbench
======================================

# temperature_sampler

Periodically reads a 13-bit two's-complement SPI temperature sensor (0.0625 °C/LSB, 16-bit frame, data in bits [15:3]) and converts each reading to an unsigned whole-degree Celsius value. It sits directly upstream of the hex display stage and drives its `binary_temperature[9:0]` input. The block owns the sensor's SPI bus (mode 0, read-only) and the sampling schedule.

## Interface
- `CLK_DIV`, 25: clk cycles per SCLK half-period (≥1; 25 gives 1 MHz SCLK from 50 MHz).
- `SAMPLE_PERIOD`, 5_000_000: clk cycles between conversion starts; must be ≥ 34·CLK_DIV+2.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `sensor_miso` in 1: sensor serial data.
- `sensor_sclk` out 1: SPI clock, idles low.
- `sensor_cs_n` out 1: sensor chip select, active low.
- `binary_temperature` out 10: whole °C, 0–255, floor of reading, negatives clamped to 0.
- `temp_valid` out 1: one-cycle pulse when `binary_temperature` updates.
- `temp_negative` out 1: last good reading was below 0 °C.
- `sensor_fault` out 1: last frame was 16'hFFFF (sensor absent / MISO stuck high).

## Operation
- Reset values: `sensor_cs_n`=1, `sensor_sclk`=0, `binary_temperature`=0, `temp_valid`=0, `temp_negative`=0, `sensor_fault`=0; FSM in IDLE; period counter 0.
- Period counter counts 0..SAMPLE_PERIOD-1, wraps, free-running. A conversion starts when counter==0 and FSM is IDLE; otherwise that start is skipped.
- FSM states:
  - IDLE: cs_n=1, sclk=0. Go to CS_SETUP on start.
  - CS_SETUP: cs_n=0, sclk=0 for CLK_DIV cycles -> SHIFT.
  - SHIFT: 16 bits, MSB first. Per bit: sclk low CLK_DIV cycles, then sclk high CLK_DIV cycles. MISO is registered into the shift register on the cycle sclk rises. After the 16th high phase sclk returns low -> CS_HOLD.
  - CS_HOLD: cs_n=0, sclk=0 for CLK_DIV cycles -> UPDATE.
  - UPDATE: cs_n=1; evaluate frame for one cycle -> IDLE.
- UPDATE evaluation, with frame F and T = F[15:3] signed:
  - F==16'hFFFF: `sensor_fault`=1; temperature, `temp_negative` held; no `temp_valid`.
  - otherwise `sensor_fault`=0; W = T >>> 4 (arithmetic, floor). If T<0 then value=0 and `temp_negative`=1, else value=W zero-extended to 10 bits and `temp_negative`=0. `temp_valid` pulses.
- `sensor_fault` clears on the next good frame.

## Timing
- Frame: cs_n low for 34·CLK_DIV cycles; total conversion 34·CLK_DIV+1 cycles from leaving IDLE to returning.
- `binary_temperature`, `temp_negative`, `sensor_fault`, `temp_valid` are all registered and change on the clock edge that ends UPDATE. `temp_valid` is high for exactly one cycle.
- The first conversion starts on the first cycle after reset deasserts.
- Reset mid-frame: on that edge cs_n=1 and sclk=0, the frame is discarded, outputs take reset values, and no `temp_valid` is issued.
- Outputs are stable between updates; a skipped start has no effect on them.

## Configuration
- `TEMP_AVG_EN` defined: a 4-entry history of accepted (clamped) values; output = floor(sum/4). The first good sample after reset fills all 4 entries. Faulted frames are not entered. `temp_negative` still reflects the latest sample. Latency is unchanged.
- Undefined: output is the latest accepted value; no history registers.

## Test plan
- MISO model returns 0x0C80 (25.0 °C) -> `binary_temperature`=25, `temp_negative`=0, one `temp_valid` pulse, cs_n low exactly 34·CLK_DIV cycles, 16 sclk rises.
- Frame 0x0CF8 (25.9375 °C) -> 25. Frame 0xF380 (−25 °C) -> 0 with `temp_negative`=1.
- After a good 25 °C reading, frame 0xFFFF -> `sensor_fault`=1, no `temp_valid`, output holds 25. Next frame 0x0C80 -> fault cleared.
- Reset asserted after 8 sclk rises -> same edge cs_n=1, sclk=0, outputs 0, no valid; a new frame starts on the first cycle after release.
- SAMPLE_PERIOD at its minimum, then shorter than the frame (bench override) -> overlapping starts are skipped, and frames never truncate.
- `TEMP_AVG_EN`: frames 0x0A00, 0x0C00, 0x0E00, 0x1000 (20, 24, 28, 32 °C) -> outputs 20, 21, 23, 26.

Source files
------------

// File: rtl/temperature_sampler.sv
// temperature_sampler: periodic SPI read of a 13-bit two's-complement
// temperature sensor (0.0625 C/LSB, data in frame bits [15:3]) converted to
// an unsigned whole-degree value for the hex display stage.
// Optional build macro: TEMP_AVG_EN enables a 4-sample running average.
module temperature_sampler #(
    parameter int CLK_DIV       = 25,
    parameter int SAMPLE_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_miso,
    output logic       sensor_sclk,
    output logic       sensor_cs_n,
    output logic [9:0] binary_temperature,
    output logic       temp_valid,
    output logic       temp_negative,
    output logic       sensor_fault
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        UPDATE
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [3:0]       bit_cnt, bit_next;
    logic             phase_high, phase_next;
    logic             sclk_next, cs_n_next;
    logic             capture;
    logic [PER_W-1:0] period_cnt;
    logic [15:0]      shift_reg;

    // Frame decode: T = F[15:3]; floor(T/16) = T[12:4], so the whole-degree
    // magnitude of a non-negative reading is simply F[14:7].
    logic       frame_fault;
    logic       sample_neg;
    logic [7:0] sample_value;
    logic [9:0] next_temp;

    assign frame_fault  = (shift_reg == 16'hFFFF);
    assign sample_neg   = shift_reg[15];
    assign sample_value = sample_neg ? 8'd0 : shift_reg[14:7];

    // Free-running sampling schedule counter
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (period_cnt == PER_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Next-state, bit timing and SPI pin decode
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        phase_next = phase_high;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (period_cnt == '0) begin
                    state_next = CS_SETUP;
                    div_next   = '0;
                end
            end
            CS_SETUP: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = SHIFT;
                    div_next   = '0;
                    bit_next   = '0;
                    phase_next = 1'b0;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (!phase_high) begin
                        phase_next = 1'b1;
                        capture    = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            state_next = CS_HOLD;
                        end else begin
                            bit_next = bit_cnt + 4'd1;
                        end
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            CS_HOLD: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = UPDATE;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            UPDATE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Pins are registered from the next-state decode so they stay glitch-free
        // yet track the FSM state cycle for cycle.
        sclk_next = (state_next == SHIFT) && phase_next;
        cs_n_next = (state_next == IDLE) || (state_next == UPDATE);
    end

    // FSM state, SPI pins and receive shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            phase_high  <= 1'b0;
            sensor_sclk <= 1'b0;
            sensor_cs_n <= 1'b1;
            shift_reg   <= '0;
        end else begin
            state       <= state_next;
            div_cnt     <= div_next;
            bit_cnt     <= bit_next;
            phase_high  <= phase_next;
            sensor_sclk <= sclk_next;
            sensor_cs_n <= cs_n_next;
            if (capture) begin
                shift_reg <= {shift_reg[14:0], sensor_miso};
            end
        end
    end

`ifdef TEMP_AVG_EN
    // Only three past values are stored; the incoming sample is the fourth entry.
    logic [7:0] hist0, hist1, hist2;
    logic       hist_primed;
    logic [9:0] avg_sum;

    // Running sum over the new sample plus history; an unprimed history counts
    // the new sample four times
    always_comb begin
        avg_sum = {sample_value, 2'b00};
        if (hist_primed) begin
            avg_sum = {2'b00, sample_value} + {2'b00, hist0} +
                      {2'b00, hist1} + {2'b00, hist2};
        end
        next_temp = avg_sum >> 2;
    end

    // History of accepted (non-faulted) samples
    always_ff @(posedge clk) begin
        if (reset) begin
            hist0       <= '0;
            hist1       <= '0;
            hist2       <= '0;
            hist_primed <= 1'b0;
        end else if (state == UPDATE && !frame_fault) begin
            hist_primed <= 1'b1;
            hist0       <= sample_value;
            hist1       <= hist_primed ? hist0 : sample_value;
            hist2       <= hist_primed ? hist1 : sample_value;
        end
    end
`else
    assign next_temp = {2'b00, sample_value};
`endif

    // Result registers, updated on the edge that ends UPDATE
    always_ff @(posedge clk) begin
        if (reset) begin
            binary_temperature <= '0;
            temp_valid         <= 1'b0;
            temp_negative      <= 1'b0;
            sensor_fault       <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            if (state == UPDATE) begin
                if (frame_fault) begin
                    sensor_fault <= 1'b1;
                end else begin
                    sensor_fault       <= 1'b0;
                    temp_negative      <= sample_neg;
                    binary_temperature <= next_temp;
                    temp_valid         <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temperature_sampler.sv
// Directed, table-driven bench for temperature_sampler (CLK_DIV=2).
module tb_temperature_sampler;

    localparam int CD       = 2;
    localparam int SP_MIN   = 34 * CD + 2;
    localparam int SP_SHORT = 30;
    localparam int CS_LOW   = 34 * CD;
    localparam int NV       = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       miso_a, sclk_a, cs_n_a, valid_a, neg_a, fault_a;
    logic [9:0] temp_a;
    logic       miso_b, sclk_b, cs_n_b, valid_b, neg_b, fault_b;
    logic [9:0] temp_b;
    logic [15:0] frame_a = 16'h0000;
    logic [15:0] frame_b = 16'h0C80;

    temperature_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_MIN)) dut (
        .clk(clk), .reset(reset), .sensor_miso(miso_a),
        .sensor_sclk(sclk_a), .sensor_cs_n(cs_n_a),
        .binary_temperature(temp_a), .temp_valid(valid_a),
        .temp_negative(neg_a), .sensor_fault(fault_a)
    );

    temperature_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_SHORT)) dut_short (
        .clk(clk), .reset(reset), .sensor_miso(miso_b),
        .sensor_sclk(sclk_b), .sensor_cs_n(cs_n_b),
        .binary_temperature(temp_b), .temp_valid(valid_b),
        .temp_negative(neg_b), .sensor_fault(fault_b)
    );

    // Sensor models: MSB presented when selected, next bit after each SCLK fall
    logic [3:0] idx_a = 4'd15;
    logic [3:0] idx_b = 4'd15;
    always @(negedge sclk_a or posedge cs_n_a)
        if (cs_n_a) idx_a <= 4'd15; else idx_a <= idx_a - 4'd1;
    always @(negedge sclk_b or posedge cs_n_b)
        if (cs_n_b) idx_b <= 4'd15; else idx_b <= idx_b - 4'd1;
    assign miso_a = frame_a[idx_a];
    assign miso_b = frame_b[idx_b];

    // Cycle-stamped monitors for conversion spacing and chip-select width
    int cyc = 0;
    int last_va = 0, iv_a = 0;
    int last_vb = 0, iv_b = 0, run_b = 0, cs_run_b = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            last_va <= 0;
            last_vb <= 0;
            run_b   <= 0;
        end else begin
            if (valid_a) begin
                if (last_va != 0) iv_a <= cyc - last_va;
                last_va <= cyc;
            end
            if (valid_b) begin
                if (last_vb != 0) iv_b <= cyc - last_vb;
                last_vb <= cyc;
            end
            if (!cs_n_b) run_b <= run_b + 1;
            else if (run_b != 0) begin
                cs_run_b <= run_b;
                run_b    <= 0;
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for chip select, then counts low cycles and SCLK rises; returns
    // in the UPDATE cycle (cs_n just deasserted)
    task automatic observe_frame(output int cs_low, output int rises, output bit timed_out);
        int   n;
        logic prev;
        n = 0; prev = 1'b0; cs_low = 0; rises = 0; timed_out = 1'b0;
        while (cs_n_a && n < 200) begin tick(); n++; end
        if (cs_n_a) begin timed_out = 1'b1; return; end
        n = 0;
        while (!cs_n_a && n < 500) begin
            cs_low++;
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            tick();
            n++;
        end
        if (!cs_n_a) timed_out = 1'b1;
    endtask

    typedef struct {
        logic [15:0] frame;
        int          temp;
        bit          neg;
        bit          fault;
        bit          valid;
    } vec_t;

    vec_t vecs[NV];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},  cs_n_a,  1);
        check({tag, "_sclk"},  sclk_a,  0);
        check({tag, "_temp"},  temp_a,  0);
        check({tag, "_valid"}, valid_a, 0);
        check({tag, "_neg"},   neg_a,   0);
        check({tag, "_fault"}, fault_a, 0);
    endtask

    initial begin
        int   cl, rs, n;
        bit   to;
        logic prev;

`ifdef TEMP_AVG_EN
        vecs[0] = '{16'h0A00,  20, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0C00,  21, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h0E00,  23, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h1000,  26, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF,  26, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0C80,  27, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'hF380,  21, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h7FF8,  78, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'h0008,  70, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'hFFFF,  70, 1'b0, 1'b1, 1'b0};
`else
        vecs[0] = '{16'h0C80,  25, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0CF8,  25, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'hF380,   0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0C80,  25, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF,  25, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0C80,  25, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'hFFF8,   0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h0008,   0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{16'h7FF8, 255, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'hFFFF, 255, 1'b0, 1'b1, 1'b0};
`endif

        // Reset state, then the first conversion starts right after release
        frame_a = vecs[0].frame;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();
        check("first_start_cs_n", cs_n_a, 0);

        for (int i = 0; i < NV; i++) begin
            frame_a = vecs[i].frame;
            observe_frame(cl, rs, to);
            check("frame_timeout", to, 0);
            check("cs_low_cycles", cl, CS_LOW);
            check("sclk_rises", rs, 16);
            tick();
            check("temp",  temp_a,  vecs[i].temp);
            check("neg",   neg_a,   vecs[i].neg);
            check("fault", fault_a, vecs[i].fault);
            check("valid", valid_a, vecs[i].valid);
            tick();
            check("valid_one_cycle", valid_a, 0);
        end

        // Reset after 8 SCLK rises: frame abandoned, outputs cleared
        frame_a = 16'h0C80;
        n = 0;
        while (cs_n_a && n < 200) begin tick(); n++; end
        check("midreset_frame_seen", cs_n_a, 0);
        n = 0; rs = 0; prev = 1'b0;
        while (rs < 8 && n < 500) begin
            if (sclk_a && !prev) rs++;
            prev = sclk_a;
            if (rs < 8) begin tick(); n++; end
        end
        check("midreset_rises", rs, 8);
        reset = 1'b1;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        tick();
        check("restart_cs_n", cs_n_a, 0);
        check("restart_no_valid", valid_a, 0);
        observe_frame(cl, rs, to);
        check("restart_timeout", to, 0);
        check("restart_cs_low", cl, CS_LOW);
        tick();
        check("restart_temp",  temp_a,  25);
        check("restart_valid", valid_a, 1);

        // Conversion spacing: minimum period back to back, short period skips starts
        repeat (400) tick();
        check("period_min_interval", iv_a, SP_MIN);
        check("period_short_interval", iv_b, 90);
        check("period_short_cs_low", cs_run_b, CS_LOW);
        check("period_short_temp", temp_b, 25);
        check("period_short_fault", fault_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
